// File: rtl/hyper_ck_diff_mon.sv
// Receive-end monitor for the gated differential HyperBus clock pair CK/CK#.
// Synchronizes both legs, detects CK edges, counts rising edges, measures the
// CK period in clk_i cycles, tracks active/idle bursts and flags loss of
// complementarity between CK and CK#.
module hyper_ck_diff_mon #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned IDLE_TIMEOUT  = 16,
  parameter int unsigned ERR_TOLERANCE = 2,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned PER_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ck_i,
  input  logic             ck_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic             ck_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             active_o,
  output logic [CNT_W-1:0] edge_cnt_o,
  output logic [PER_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             diff_err_o
);

  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned MM_MAX = ERR_TOLERANCE + 1;
  localparam int unsigned MM_W   = $clog2(MM_MAX + 1);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] ck_sync_q;
  logic [SYNC_STAGES-1:0] ckn_sync_q;
  logic                   prev_q;
  logic                   ck_s;
  logic                   ckn_s;

  state_e                 state_q;
  logic                   active_q;
  logic [CNT_W-1:0]       edge_cnt_q;
  logic [PER_W-1:0]       period_q;
  logic                   period_valid_q;
  logic                   diff_err_q;
  logic [PER_W-1:0]       per_cnt_q;
  logic [IDLE_W-1:0]      idle_cnt_q;
  logic [MM_W-1:0]        mm_cnt_q;
  logic [MM_W-1:0]        mm_cnt_d;
  logic                   err_set_d;

  assign ck_s  = ck_sync_q[SYNC_STAGES-1];
  assign ckn_s = ckn_sync_q[SYNC_STAGES-1];

  assign ck_o           = ck_s;
  assign rise_o         = ck_s & ~prev_q & en_i;
  assign fall_o         = ~ck_s & prev_q & en_i;
  assign active_o       = active_q;
  assign edge_cnt_o     = edge_cnt_q;
  assign period_o       = period_q;
  assign period_valid_o = period_valid_q;
  assign diff_err_o     = diff_err_q;

  // Synchronizer chains; CK# resets high so the idle pair is complementary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ck_sync_q  <= '0;
      ckn_sync_q <= '1;
      prev_q     <= 1'b0;
    end else begin
      ck_sync_q  <= {ck_sync_q[SYNC_STAGES-2:0], ck_i};
      ckn_sync_q <= {ckn_sync_q[SYNC_STAGES-2:0], ck_ni};
      prev_q     <= ck_s;
    end
  end

  // Run length of equal CK/CK# samples; error on the (tolerance+1)th one.
  always_comb begin
    mm_cnt_d  = mm_cnt_q;
    err_set_d = 1'b0;
    if (state_q != ST_DISABLED) begin
      if (ck_s == ckn_s) begin
        if (mm_cnt_q >= MM_W'(ERR_TOLERANCE)) begin
          err_set_d = 1'b1;
        end
        if (mm_cnt_q != MM_W'(MM_MAX)) begin
          mm_cnt_d = mm_cnt_q + MM_W'(1);
        end
      end else begin
        mm_cnt_d = '0;
      end
    end
  end

  // Burst FSM, edge counter, period measurement and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_DISABLED;
      active_q       <= 1'b0;
      edge_cnt_q     <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      diff_err_q     <= 1'b0;
      per_cnt_q      <= '0;
      idle_cnt_q     <= '0;
      mm_cnt_q       <= '0;
    end else begin
      mm_cnt_q <= mm_cnt_d;
      if (!en_i) begin
        state_q  <= ST_DISABLED;
        active_q <= 1'b0;
      end else begin
        case (state_q)
          ST_DISABLED: begin
            state_q <= ST_IDLE;
          end
          ST_IDLE: begin
            // First rise of a burst starts timing but has no prior rise to measure from.
            if (rise_o) begin
              state_q    <= ST_ACTIVE;
              active_q   <= 1'b1;
              per_cnt_q  <= PER_W'(1);
              idle_cnt_q <= '0;
              edge_cnt_q <= edge_cnt_q + CNT_W'(1);
            end
          end
          ST_ACTIVE: begin
            if (rise_o) begin
              per_cnt_q      <= PER_W'(1);
              edge_cnt_q     <= edge_cnt_q + CNT_W'(1);
              period_q       <= per_cnt_q;
              period_valid_q <= 1'b1;
            end else if (per_cnt_q != '1) begin
              per_cnt_q <= per_cnt_q + PER_W'(1);
            end
            if (rise_o || fall_o) begin
              idle_cnt_q <= '0;
            end else if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
              state_q        <= ST_IDLE;
              active_q       <= 1'b0;
              period_valid_q <= 1'b0;
              idle_cnt_q     <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            end
          end
          default: begin
            state_q  <= ST_DISABLED;
            active_q <= 1'b0;
          end
        endcase
      end
      // Clear overrides a same-cycle rise; a same-cycle error set overrides clear.
      if (clr_i) begin
        edge_cnt_q     <= '0;
        period_q       <= '0;
        period_valid_q <= 1'b0;
        diff_err_q     <= 1'b0;
      end
      if (err_set_d) begin
        diff_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hyper_ck_diff_mon.sv
// Bench for hyper_ck_diff_mon: randomized CK bursts with an event-level model
// feeding a scoreboard that a monitor drains on every rise_o pulse.
module tb_hyper_ck_diff_mon;

  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned IDLE_TIMEOUT  = 16;
  localparam int unsigned ERR_TOLERANCE = 2;
  localparam int unsigned CNT_W         = 4;
  localparam int unsigned PER_W         = 8;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             ck_i;
  logic             ck_ni;
  logic             en_i;
  logic             clr_i;
  logic             ck_o;
  logic             rise_o;
  logic             fall_o;
  logic             active_o;
  logic [CNT_W-1:0] edge_cnt_o;
  logic [PER_W-1:0] period_o;
  logic             period_valid_o;
  logic             diff_err_o;

  hyper_ck_diff_mon #(
    .SYNC_STAGES  (SYNC_STAGES),
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .ERR_TOLERANCE(ERR_TOLERANCE),
    .CNT_W        (CNT_W),
    .PER_W        (PER_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .ck_i          (ck_i),
    .ck_ni         (ck_ni),
    .en_i          (en_i),
    .clr_i         (clr_i),
    .ck_o          (ck_o),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .active_o      (active_o),
    .edge_cnt_o    (edge_cnt_o),
    .period_o      (period_o),
    .period_valid_o(period_valid_o),
    .diff_err_o    (diff_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int per;
    bit pv;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: rising-edge count, last period, valid flag, in-burst flag.
  int   m_cnt   = 0;
  int   m_per   = 0;
  bit   m_pv    = 0;
  bit   m_burst = 0;

  bit   arm_clr = 0;
  bit   clr_req = 0;
  int   hl;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge of CK as seen by the model; per = clk cycles since the previous rise.
  task automatic model_rise(input bit clr, input int per);
    exp_t e;
    if (m_burst && !clr) begin
      m_per = per;
      m_pv  = 1'b1;
    end
    m_burst = 1'b1;
    if (clr) begin
      m_cnt = 0;
      m_per = 0;
      m_pv  = 1'b0;
    end else begin
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    e.cnt = m_cnt;
    e.per = m_per;
    e.pv  = m_pv;
    q.push_back(e);
  endtask

  task automatic model_end();
    m_burst = 1'b0;
    m_pv    = 1'b0;
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m_per = 0;
    m_pv  = 1'b0;
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      ck_i  = v;
      ck_ni = ~v;
    end
  endtask

  // Burst of n rises; h >= 2 keeps consecutive rise pulses at least 3 cycles apart.
  task automatic burst(input int n, input int clr_idx, input int fh, input int fl,
                       output int last_hl);
    int h;
    int l;
    int prev;
    prev = 0;
    for (int i = 0; i < n; i++) begin
      h = (fh > 0) ? fh : int'($urandom_range(8, 2));
      l = (fl > 0) ? fl : int'($urandom_range(8, 1));
      model_rise(i == clr_idx, prev);
      @(negedge clk);
      ck_i  = 1'b1;
      ck_ni = 1'b0;
      if (i == clr_idx) arm_clr = 1'b1;
      drive(1'b1, h - 1);
      drive(1'b0, l);
      prev = h + l;
    end
    last_hl = prev;
  endtask

  // Final rise of a burst, then CK parked low; active_o must drop after 16
  // edge-free cycles following the fall-pulse cycle.
  task automatic end_measured(input int prev_hl);
    int fall_at;
    int low_at;
    fall_at = -1;
    low_at  = -1;
    model_rise(1'b0, prev_hl);
    @(negedge clk);
    ck_i  = 1'b1;
    ck_ni = 1'b0;
    drive(1'b1, 3);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (fall_o && fall_at < 0) fall_at = k;
      if (fall_at >= 0 && !active_o && low_at < 0) low_at = k;
      ck_i  = 1'b0;
      ck_ni = 1'b1;
    end
    check("idle_timeout_latency", low_at - fall_at, int'(IDLE_TIMEOUT) + 1);
    model_end();
    check("idle_active", int'(active_o), 0);
    check("idle_period_valid", int'(period_valid_o), int'(m_pv));
    check("idle_period_hold", int'(period_o), m_per);
    check("idle_edge_cnt", int'(edge_cnt_o), m_cnt);
  endtask

  task automatic clr_pulse();
    @(posedge clk);
    #1 clr_req = 1'b1;
    @(posedge clk);
    #1 clr_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // clr_i driver: standalone clears, or a clear landing exactly on an armed rise pulse.
  initial begin
    clr_i = 1'b0;
    forever begin
      @(negedge clk);
      if (arm_clr && rise_o) begin
        clr_i   = 1'b1;
        arm_clr = 1'b0;
      end else begin
        clr_i = clr_req;
      end
    end
  end

  // Monitor: every rise_o pulse consumes one expectation, checked one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && rise_o) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rise: rise_o=1 with no rise expected at %0t", $time);
        end else begin
          e = q.pop_front();
          @(negedge clk);
          check("sb_edge_cnt", int'(edge_cnt_o), e.cnt);
          check("sb_period", int'(period_o), e.per);
          check("sb_period_valid", int'(period_valid_o), int'(e.pv));
          check("sb_active", int'(active_o), 1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    en_i  = 1'b1;
    ck_i  = 1'b0;
    ck_ni = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ck_o", int'(ck_o), 0);
    check("rst_rise", int'(rise_o), 0);
    check("rst_active", int'(active_o), 0);
    check("rst_edge_cnt", int'(edge_cnt_o), 0);
    check("rst_period", int'(period_o), 0);
    check("rst_period_valid", int'(period_valid_o), 0);
    check("rst_diff_err", int'(diff_err_o), 0);
    rst_i = 1'b0;
    repeat (30) @(negedge clk);
    check("static_active", int'(active_o), 0);
    check("static_edge_cnt", int'(edge_cnt_o), 0);
    check("static_diff_err", int'(diff_err_o), 0);

    // Synchronizer latency: visible on the second negedge after driving CK high.
    model_rise(1'b0, 0);
    @(negedge clk);
    ck_i  = 1'b1;
    ck_ni = 1'b0;
    @(negedge clk);
    check("lat_ck_o_early", int'(ck_o), 0);
    @(negedge clk);
    check("lat_ck_o", int'(ck_o), 1);
    check("lat_rise", int'(rise_o), 1);
    drive(1'b1, 2);
    drive(1'b0, IDLE_TIMEOUT + 6);
    model_end();
    check("lat_idle_active", int'(active_o), 0);

    // Fixed period 8 (4 high / 4 low).
    burst(5, -1, 4, 4, hl);
    check("p8_period", int'(period_o), 8);
    end_measured(hl);

    // Random bursts.
    repeat (3) begin
      burst(int'($urandom_range(10, 3)), -1, 0, 0, hl);
      end_measured(hl);
    end

    // Clear coinciding with a rise pulse: first rise of burst, then mid-burst.
    clr_pulse();
    model_clear();
    check("clr_edge_cnt", int'(edge_cnt_o), 0);
    check("clr_period_valid", int'(period_valid_o), 0);
    burst(4, 0, 0, 0, hl);
    end_measured(hl);
    burst(5, 2, 0, 0, hl);
    end_measured(hl);

    // 17 rises into a 4-bit counter wrap to 1.
    clr_pulse();
    model_clear();
    burst(16, -1, 0, 0, hl);
    end_measured(hl);
    check("wrap17_edge_cnt", int'(edge_cnt_o), 1);

    // Differential check: 2 equal samples tolerated, 3 flag a sticky error.
    @(negedge clk);
    ck_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ck_ni = 1'b1;
    repeat (8) @(negedge clk);
    check("diff_two_equal", int'(diff_err_o), 0);
    @(negedge clk);
    ck_ni = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    ck_ni = 1'b1;
    repeat (8) @(negedge clk);
    check("diff_three_equal", int'(diff_err_o), 1);
    repeat (20) @(negedge clk);
    check("diff_sticky", int'(diff_err_o), 1);
    clr_pulse();
    model_clear();
    check("diff_cleared", int'(diff_err_o), 0);

    // Drop enable mid-burst: counts freeze, no rise pulses, values hold.
    burst(3, -1, 0, 0, hl);
    @(negedge clk);
    en_i    = 1'b0;
    m_burst = 1'b0;
    repeat (3) begin
      drive(1'b1, 3);
      drive(1'b0, 3);
    end
    drive(1'b0, 4);
    check("dis_active", int'(active_o), 0);
    check("dis_edge_cnt", int'(edge_cnt_o), m_cnt);
    check("dis_period", int'(period_o), m_per);
    check("dis_period_valid", int'(period_valid_o), int'(m_pv));
    @(negedge clk);
    en_i = 1'b1;
    drive(1'b0, 4);
    burst(3, -1, 0, 0, hl);
    end_measured(hl);

    repeat (5) @(negedge clk);
    check("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
